// File: rtl/dadz_arb_pkg.sv
// dadz_arb_pkg: shared Q6.10 constants and helpers for the sigmoid-derivative arbiter.
// Optional feature macro: DADZ_ARB_CLAMP_EN (clamps a to [0, ONE] before S1).
package dadz_arb_pkg;

    localparam int W       = 16;
    localparam int FRAC    = 10;
    localparam logic signed [15:0] ONE = 16'sh0400;

    localparam int PROD_W  = 32;
    localparam int PROD_HI = 25;
    localparam int PROD_LO = 10;

    // Limit a sigmoid output to the legal range [0.0, 1.0]
    function automatic logic [W-1:0] clamp_a(input logic [W-1:0] a);
        if ($signed(a) < 0)
            return '0;
        else if ($signed(a) > ONE)
            return ONE;
        else
            return a;
    endfunction

endpackage

// File: rtl/dadz_core.sv
// dadz_core: registered multiply stage computing (ONE - a) * a in Q6.10,
// with valid/id passthrough and a hold enable for downstream back-pressure.
module dadz_core #(
    parameter int W   = 16,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           res,
    input  logic           hold,
    input  logic           in_valid,
    input  logic [W-1:0]   in_a,
    input  logic [IDW-1:0] in_id,
    output logic           out_valid,
    output logic [W-1:0]   out_dadz,
    output logic [IDW-1:0] out_id
);

    import dadz_arb_pkg::*;

    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] one_minus_a;
    logic signed [PROD_W-1:0] prod;

    // Full 32-bit signed product; the Q6.10 result is bits [25:10] (plain truncation)
    assign a_ext       = PROD_W'($signed(in_a));
    assign one_minus_a = PROD_W'(ONE) - a_ext;
    assign prod        = one_minus_a * a_ext;

    // S2 register: captures the product unless the output is stalled
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            out_valid <= 1'b0;
            out_dadz  <= '0;
            out_id    <= '0;
        end else if (!hold) begin
            out_valid <= in_valid;
            out_dadz  <= W'(prod >>> PROD_LO);
            out_id    <= in_id;
        end
    end

endmodule

// File: rtl/dadz_arb.sv
// dadz_arb: round-robin arbiter sharing one two-stage da/dz pipeline among NREQ requesters.
// S1 (granted a + id) lives here, S2 (product) lives in dadz_core.
// Optional feature macro: DADZ_ARB_CLAMP_EN clamps a to [0, ONE] before S1.
module dadz_arb #(
    parameter int NREQ = 3,
    parameter int W    = 16
) (
    input  logic                      clk,
    input  logic                      res,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*W-1:0]         req_a,
    output logic [NREQ-1:0]           req_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(NREQ)-1:0]   out_id,
    output logic [W-1:0]              out_dadz,
    output logic [1:0]                inflight
);

    import dadz_arb_pkg::*;

    localparam int IDW = $clog2(NREQ);

    logic           s1_valid;
    logic [W-1:0]   s1_a;
    logic [IDW-1:0] s1_id;
    logic [IDW-1:0] last_grant;

    logic           stall;
    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand_idx;
    logic           accept;
    logic [W-1:0]   grant_a;
    logic [W-1:0]   grant_a_c;

    assign stall  = out_valid & ~out_ready;
    assign accept = |req_ready;

    // Round-robin search starting one past the last granted requester
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand_idx = IDW'((int'(last_grant) + i) % NREQ);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // One-hot acceptance, suppressed while stalled or held in reset
    always_comb begin
        req_ready = '0;
        if (grant_found && !stall && res)
            req_ready[grant_idx] = 1'b1;
    end

    assign grant_a = req_a[grant_idx*W +: W];

`ifdef DADZ_ARB_CLAMP_EN
    assign grant_a_c = clamp_a(grant_a);
`else
    assign grant_a_c = grant_a;
`endif

    // S1 register and grant pointer; both freeze during a stall
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_id      <= '0;
            last_grant <= IDW'(NREQ - 1);
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_a       <= grant_a_c;
                s1_id      <= grant_idx;
                last_grant <= grant_idx;
            end
        end
    end

    dadz_core #(
        .W   (W),
        .IDW (IDW)
    ) u_core (
        .clk       (clk),
        .res       (res),
        .hold      (stall),
        .in_valid  (s1_valid),
        .in_a      (s1_a),
        .in_id     (s1_id),
        .out_valid (out_valid),
        .out_dadz  (out_dadz),
        .out_id    (out_id)
    );

    assign inflight = 2'(s1_valid) + 2'(out_valid);

endmodule

// File: doc/dadz_arb.md
DADZ_ARB -- requirements
Module: dadz_arb

Interface
REQ-001 Parameter NREQ, default 3: number of requesters sharing one sigmoid-derivative datapath (hidden neurons i=1..3).
REQ-002 Parameter W, default 16: data width, signed Q6.10 (format 00_0000.0000_0000_00, 1.0 = 16'h0400).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 res  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NREQ  per-requester request strobe.
REQ-006 req_a  input  NREQ*W  per-requester sigmoid output a; requester k on bits [k*W +: W].
REQ-007 req_ready  output  NREQ  one-hot-or-zero acceptance; transfer when req_valid[k] & req_ready[k].
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 out_id  output  $clog2(NREQ)  index of requester owning the result.
REQ-011 out_dadz  output  W  da/dz = (1.0 - a) * a, Q6.10.
REQ-012 inflight  output  2  number of occupied pipeline stages (0..2).

Function
REQ-013 Two-stage pipeline: S1 registers granted a and id; S2 registers product and id; out_* driven from S2.
REQ-014 Latency: result appears on out_valid exactly 2 cycles after the accepting edge when no stall.
REQ-015 Stall = out_valid & ~out_ready; during stall S1, S2 and the grant pointer hold and req_ready = 0.
REQ-016 Without stall, pipeline advances every cycle; throughput one result per cycle; bubbles propagate as valid = 0.
REQ-017 Arbitration round-robin: search starts at last_grant+1 modulo NREQ; first k with req_valid[k] gets req_ready[k] = 1.
REQ-018 At most one req_ready bit high per cycle; req_ready depends combinationally on req_valid, pointer and stall only.
REQ-019 last_grant updates to granted index only on an accepted transfer; no request -> pointer holds.
REQ-020 Arithmetic: 32-bit signed product (ONE - a) * a; out_dadz = product[25:10] (truncation, no rounding, no saturation).
REQ-021 Simultaneous S2 drain (out_ready=1) and new grant in same cycle is allowed; no bubble inserted.
REQ-022 inflight = S1.valid + S2.valid, updated with the registers.

Reset
REQ-023 res low asynchronously clears S1/S2 valid, data and id to 0; out_valid = 0, out_dadz = 0, out_id = 0, inflight = 0, req_ready = 0 while res low.
REQ-024 Reset sets last_grant = NREQ-1 so requester 0 has first priority.
REQ-025 Reset asserted mid-operation discards all in-flight results; no result is emitted for them after release.

Configuration
REQ-026 Macro DADZ_ARB_CLAMP_EN defined: a is clamped to [0, ONE] before S1 (a<0 -> 0, a>ONE -> ONE).
REQ-027 Macro undefined: a passes unmodified; out-of-range a yields the raw truncated product.

Structure
REQ-028 Shared package holds ONE (16'h0400), FRAC (10), W and the Q6.10 product slice bounds.
REQ-029 Sub-module dadz_core: one registered multiply stage (S2) with valid/id passthrough and hold enable; arbiter and S1 in dadz_arb.

Verification
REQ-030 Single request k=0, a=16'h0200, out_ready=1 -> 2 cycles later out_valid=1, out_id=0, out_dadz=16'h0100.
REQ-031 All three req_valid held high, a = 16'h0300 each -> grants 0,1,2,0,... one per cycle; every out_dadz=16'h00C0, ids in same order.
REQ-032 out_ready=0 with pipeline full -> req_ready=0, inflight=2, out_* stable until out_ready=1; then drains in order, no loss or duplication.
REQ-033 a=16'h0400 and a=16'h0000 -> out_dadz=16'h0000 both.
REQ-034 a=16'hFC00 (-1.0) -> out_dadz=16'hF800 without DADZ_ARB_CLAMP_EN, 16'h0000 with it.
REQ-035 res pulsed low with inflight=2 -> outputs 0 immediately, no stale result after release, next grant goes to requester 0.
